// File: rtl/contador_pkg.sv
// Shared constants for the cascaded mod-BASE counter: digit width, digit limit
// and the per-edge operation encoding (clear > load > count > hold).
package contador_pkg;

  localparam int unsigned DIGIT_W    = 4;
  localparam int unsigned MAX_DIGITS = 8;

  typedef enum logic [1:0] {
    OP_HOLD  = 2'b00,
    OP_COUNT = 2'b01,
    OP_LOAD  = 2'b10,
    OP_CLEAR = 2'b11
  } op_e;

  function automatic op_e decode_op(input logic clear, input logic load, input logic enable);
    op_e op;
    op = OP_HOLD;
    if (clear) begin
      op = OP_CLEAR;
    end else if (load) begin
      op = OP_LOAD;
    end else if (enable) begin
      op = OP_COUNT;
    end
    return op;
  endfunction

endpackage

// File: rtl/contador_digito.sv
// One mod-BASE digit with carry/borrow ripple. Updates on the falling clock
// edge; cout_o is combinational so a whole chain settles within one edge.
module contador_digito
  import contador_pkg::*;
#(
  parameter int unsigned BASE = 10
) (
  input  logic               clock,
  input  logic               reset,
  input  op_e                op_i,
  input  logic               up_down_i,
  input  logic               cin_i,
  input  logic [DIGIT_W-1:0] load_digit_i,
  output logic [DIGIT_W-1:0] q_o,
  output logic               cout_o,
  output logic               load_bad_o
);

  localparam logic [DIGIT_W-1:0] MAXV = DIGIT_W'(BASE - 1);

  logic [DIGIT_W-1:0] q_q, q_d;
  logic               at_limit;

  assign at_limit   = up_down_i ? (q_q == MAXV) : (q_q == '0);
  assign cout_o     = cin_i & at_limit;
  assign load_bad_o = ({1'b0, load_digit_i} >= (DIGIT_W + 1)'(BASE));
  assign q_o        = q_q;

  always_comb begin
    q_d = q_q;
    unique case (op_i)
      OP_CLEAR: q_d = '0;
      OP_LOAD:  q_d = load_bad_o ? '0 : load_digit_i;
      OP_COUNT: begin
        if (cin_i) begin
          if (up_down_i) begin
            q_d = (q_q == MAXV) ? '0 : q_q + 1'b1;
          end else begin
            q_d = (q_q == '0) ? MAXV : q_q - 1'b1;
          end
        end
      end
      default: q_d = q_q;
    endcase
  end

  always_ff @(negedge clock or posedge reset) begin
    if (reset) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

endmodule

// File: rtl/contador_modn.sv
// Cascaded DIGITS x mod-BASE up/down counter, falling-edge clocked.
// Define CONTADOR_MODN_SATURATE_EN to clamp at the terminal count instead of wrapping.
module contador_modn
  import contador_pkg::*;
#(
  parameter int unsigned DIGITS = 2,
  parameter int unsigned BASE   = 10
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  enable,
  input  logic                  up_down,
  input  logic                  clear,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   load_value,
  output logic [4*DIGITS-1:0]   Q,
  output logic                  tc,
  output logic                  ovf,
  output logic                  load_err
);

  op_e               op;
  op_e               op_eff;
  logic [DIGITS:0]   carry;
  logic [DIGITS-1:0] bad;
  logic              ovf_q, ovf_d;
  logic              load_err_q, load_err_d;

  assign op = decode_op(clear, load, enable);

  // Chain seeded with enable: the final carry-out is exactly the terminal count.
  assign carry[0] = enable;
  assign tc       = carry[DIGITS];

`ifdef CONTADOR_MODN_SATURATE_EN
  assign op_eff = ((op == OP_COUNT) && tc) ? OP_HOLD : op;
`else
  assign op_eff = op;
`endif

  for (genvar g = 0; g < DIGITS; g++) begin : g_digit
    contador_digito #(
      .BASE(BASE)
    ) u_digito (
      .clock        (clock),
      .reset        (reset),
      .op_i         (op_eff),
      .up_down_i    (up_down),
      .cin_i        (carry[g]),
      .load_digit_i (load_value[g*DIGIT_W +: DIGIT_W]),
      .q_o          (Q[g*DIGIT_W +: DIGIT_W]),
      .cout_o       (carry[g+1]),
      .load_bad_o   (bad[g])
    );
  end

  always_comb begin
    ovf_d      = (op == OP_COUNT) && tc;
    load_err_d = (op == OP_LOAD) && (|bad);
  end

  always_ff @(negedge clock or posedge reset) begin
    if (reset) begin
      ovf_q      <= 1'b0;
      load_err_q <= 1'b0;
    end else begin
      ovf_q      <= ovf_d;
      load_err_q <= load_err_d;
    end
  end

  assign ovf      = ovf_q;
  assign load_err = load_err_q;

endmodule

// File: tb/tb_contador_modn.sv
// Scoreboard bench for contador_modn (DIGITS=2, BASE=10); expectations adapt
// when CONTADOR_MODN_SATURATE_EN is defined.
module tb_contador_modn;

`ifdef CONTADOR_MODN_SATURATE_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       enable = 1'b0;
  logic       up_down = 1'b0;
  logic       clear = 1'b0;
  logic       load = 1'b0;
  logic [7:0] load_value = '0;
  logic [7:0] Q;
  logic       tc, ovf, load_err;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [7:0] q;
    logic       tc;
    logic       ovf;
    logic       lerr;
    string      name;
  } exp_t;

  exp_t sb[$];

  contador_modn #(.DIGITS(2), .BASE(10)) dut (
    .clock      (clock),
    .reset      (reset),
    .enable     (enable),
    .up_down    (up_down),
    .clear      (clear),
    .load       (load),
    .load_value (load_value),
    .Q          (Q),
    .tc         (tc),
    .ovf        (ovf),
    .load_err   (load_err)
  );

  always #5 clock = ~clock;

  task automatic cmp(input string nm, input string fld, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s.%s: got %h expected %h", nm, fld, act, exp);
    end
  endtask

  task automatic push(input string nm, input logic [7:0] eq, input logic etc, input logic eo, input logic el);
    exp_t e;
    e.q = eq; e.tc = etc; e.ovf = eo; e.lerr = el; e.name = nm;
    sb.push_back(e);
  endtask

  // Inputs change mid-high-phase, the DUT updates on the falling edge, and the
  // expected response becomes visible to the monitor at the next rising edge.
  task automatic apply(input string nm, input logic rs, input logic cl, input logic ld,
                       input logic en, input logic ud, input logic [7:0] lv,
                       input logic [7:0] eq, input logic etc, input logic eo, input logic el);
    @(posedge clock);
    #2;
    reset = rs; clear = cl; load = ld; enable = en; up_down = ud; load_value = lv;
    @(negedge clock);
    #1;
    push(nm, eq, etc, eo, el);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clock);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        cmp(e.name, "Q", Q, e.q);
        cmp(e.name, "tc", {7'b0, tc}, {7'b0, e.tc});
        cmp(e.name, "ovf", {7'b0, ovf}, {7'b0, e.ovf});
        cmp(e.name, "load_err", {7'b0, load_err}, {7'b0, e.lerr});
      end
    end
  end

  initial begin : stim
    //     name        rs cl ld en ud lv      Q                        tc          ovf         lerr
    apply("reset",     1, 0, 0, 0, 0, 8'h00, 8'h00,                   0,          0,          0);
    apply("load98",    0, 0, 1, 0, 1, 8'h98, 8'h98,                   0,          0,          0);
    apply("up99",      0, 0, 0, 1, 1, 8'h00, 8'h99,                   1,          0,          0);
    apply("upwrap",    0, 0, 0, 1, 1, 8'h00, SAT ? 8'h99 : 8'h00,     SAT,        1,          0);
    apply("up_b",      0, 0, 0, 1, 1, 8'h00, SAT ? 8'h99 : 8'h01,     SAT,        SAT,        0);
    apply("up_c",      0, 0, 0, 1, 1, 8'h00, SAT ? 8'h99 : 8'h02,     SAT,        SAT,        0);
    apply("hold",      0, 0, 0, 0, 1, 8'h00, SAT ? 8'h99 : 8'h02,     0,          0,          0);
    apply("load10",    0, 0, 1, 0, 0, 8'h10, 8'h10,                   0,          0,          0);
    apply("down09",    0, 0, 0, 1, 0, 8'h00, 8'h09,                   0,          0,          0);
    apply("load00",    0, 0, 1, 0, 0, 8'h00, 8'h00,                   0,          0,          0);
    apply("downwrap",  0, 0, 0, 1, 0, 8'h00, SAT ? 8'h00 : 8'h99,     SAT,        1,          0);
    apply("dirup",     0, 0, 0, 1, 1, 8'h00, SAT ? 8'h01 : 8'h00,     0,          !SAT,       0);
    apply("dirdown",   0, 0, 0, 1, 0, 8'h00, SAT ? 8'h00 : 8'h99,     SAT,        !SAT,       0);
    apply("load45",    0, 0, 1, 0, 1, 8'h45, 8'h45,                   0,          0,          0);
    apply("up46",      0, 0, 0, 1, 1, 8'h00, 8'h46,                   0,          0,          0);
    apply("down45",    0, 0, 0, 1, 0, 8'h00, 8'h45,                   0,          0,          0);
    apply("down44",    0, 0, 0, 1, 0, 8'h00, 8'h44,                   0,          0,          0);
    apply("badload",   0, 0, 1, 0, 1, 8'h3C, 8'h30,                   0,          0,          1);
    apply("badhold",   0, 0, 0, 0, 1, 8'h00, 8'h30,                   0,          0,          0);
    apply("clrwins",   0, 1, 1, 1, 1, 8'h77, 8'h00,                   0,          0,          0);
    apply("loadwins",  0, 0, 1, 1, 1, 8'h23, 8'h23,                   0,          0,          0);
    apply("load47",    0, 0, 1, 0, 1, 8'h47, 8'h47,                   0,          0,          0);

    // Reset asserted between falling edges while Q=0x47; checked before the next edge.
    @(posedge clock);
    #2;
    load = 1'b0;
    @(negedge clock);
    #2;
    reset = 1'b1;
    #1;
    push("asyncrst", 8'h00, 0, 0, 0);

    apply("rsthold1",  1, 0, 0, 1, 1, 8'h00, 8'h00,                   0,          0,          0);
    apply("rsthold2",  1, 0, 0, 1, 1, 8'h00, 8'h00,                   0,          0,          0);
    apply("rsthold3",  1, 0, 0, 1, 1, 8'h00, 8'h00,                   0,          0,          0);
    apply("rstrel",    0, 0, 0, 1, 1, 8'h00, 8'h01,                   0,          0,          0);
    apply("final",     0, 0, 0, 0, 1, 8'h00, 8'h01,                   0,          0,          0);

    repeat (3) @(posedge clock);
    #1;
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expected 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
